// File: rtl/pps_marker_generator_if.sv
// pps_marker_generator_if
// Purpose: bundles the CSR access and PPS signals of pps_marker_generator
// so a CSR master (or testbench) and the generator share one connection.
// Signals:
//   csrStrobe     one-cycle CSR write strobe
//   GPIO_OUT      CSR write data (bit31 enable, bit30 resync, bit29 clear lockLost)
//   status        {enabled, armed, locked, lockLost, seconds[27:0]}
//   ppsMarker     generated 1 Hz marker, registered
//   ppsExternal_a asynchronous external PPS input
// Modports: master drives the CSR write and external PPS; slave is the generator.
interface pps_marker_generator_if;
   logic        csrStrobe;
   logic [31:0] GPIO_OUT;
   logic [31:0] status;
   logic        ppsMarker;
   logic        ppsExternal_a;

   modport master (
      output csrStrobe,
      output GPIO_OUT,
      output ppsExternal_a,
      input  status,
      input  ppsMarker
   );

   modport slave (
      input  csrStrobe,
      input  GPIO_OUT,
      input  ppsExternal_a,
      output status,
      output ppsMarker
   );
endinterface

// File: rtl/pps_marker_generator.sv
// pps_marker_generator
// Purpose: free-running 1 Hz acquisition marker. On a CSR resync request it
// phase-aligns its tick counter to an external PPS edge, then monitors that
// source and reports loss of lock.
// Ports:
//   clk    system clock, everything is synchronous to it
//   rst_n  synchronous active-low reset
//   bus    pps_marker_generator_if.slave: csrStrobe, GPIO_OUT, status,
//          ppsMarker, ppsExternal_a
module pps_marker_generator #(
   parameter int CLK_RATE    = 100000000,
   parameter int PULSE_TICKS = 10000000,
   parameter int TOLERANCE   = 100
) (
   input logic                   clk,
   input logic                   rst_n,
   pps_marker_generator_if.slave bus
);

   localparam int ALIGN_TICK  = 2;
   localparam int TICK_W      = $clog2(CLK_RATE);
   localparam int ARM_RELOAD  = 2 * CLK_RATE;
   localparam int ARM_W       = $clog2(ARM_RELOAD) + 1;
   localparam int LOCK_RELOAD = (CLK_RATE / 10) * 11;
   localparam int LOCK_W      = $clog2(LOCK_RELOAD) + 1;

   localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(CLK_RATE - 1);
   localparam logic [TICK_W-1:0] TICK_ONE     = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_PULSE   = TICK_W'(PULSE_TICKS);
   localparam logic [TICK_W-1:0] TICK_ALIGN   = TICK_W'(ALIGN_TICK);
   localparam logic [TICK_W-1:0] TICK_ALIGNED = TICK_W'(ALIGN_TICK + 1);
   localparam logic [TICK_W-1:0] ERR_WRAP     = TICK_W'(CLK_RATE - ALIGN_TICK);
   localparam logic [TICK_W-1:0] TOL_LOW      = TICK_W'(TOLERANCE);
   localparam logic [TICK_W-1:0] TOL_HIGH     = TICK_W'(CLK_RATE - TOLERANCE);
   localparam logic [ARM_W-1:0]  ARM_LAST     = ARM_W'(ARM_RELOAD - 1);
   localparam logic [ARM_W-1:0]  ARM_ONE      = ARM_W'(1);
   localparam logic [LOCK_W-1:0] LOCK_LAST    = LOCK_W'(LOCK_RELOAD - 1);
   localparam logic [LOCK_W-1:0] LOCK_ONE     = LOCK_W'(1);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      RUN      = 2'd1,
      ARMED    = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [TICK_W-1:0]   tick, tick_next;
   logic [27:0]         seconds, seconds_next;
   logic                locked, locked_next;
   logic                lock_lost, lock_lost_next;
   logic [ARM_W-1:0]    arm_cnt, arm_cnt_next;
   logic [LOCK_W-1:0]   lock_cnt, lock_cnt_next;
   logic                marker_next;

   logic                sync_m, sync_d0, sync_d1, ext_strobe;
   logic                enable_req, resync_req, clear_req;
   logic [TICK_W-1:0]   phase_err;
   logic                phase_ok;

   logic                unused_gpio_bits;

   assign enable_req       = bus.GPIO_OUT[31];
   assign resync_req       = bus.GPIO_OUT[30];
   assign clear_req        = bus.GPIO_OUT[29];
   assign unused_gpio_bits = ^bus.GPIO_OUT[28:0];

   // Phase error of the external edge relative to the aligned position,
   // taken modulo the marker period so early edges land near CLK_RATE.
   assign phase_err = (tick >= TICK_ALIGN) ? (tick - TICK_ALIGN) : (tick + ERR_WRAP);
   assign phase_ok  = (phase_err <= TOL_LOW) || (phase_err >= TOL_HIGH);

   // Three-flop synchronizer plus rising-edge detect on the external PPS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_m     <= 1'b0;
         sync_d0    <= 1'b0;
         sync_d1    <= 1'b0;
         ext_strobe <= 1'b0;
      end else begin
         sync_m     <= bus.ppsExternal_a;
         sync_d0    <= sync_m;
         sync_d1    <= sync_d0;
         ext_strobe <= sync_d0 & ~sync_d1;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= DISABLED;
         tick          <= '0;
         seconds       <= '0;
         locked        <= 1'b0;
         lock_lost     <= 1'b0;
         arm_cnt       <= '0;
         lock_cnt      <= '0;
         bus.ppsMarker <= 1'b0;
      end else begin
         state         <= state_next;
         tick          <= tick_next;
         seconds       <= seconds_next;
         locked        <= locked_next;
         lock_lost     <= lock_lost_next;
         arm_cnt       <= arm_cnt_next;
         lock_cnt      <= lock_cnt_next;
         bus.ppsMarker <= marker_next;
      end
   end

   // Next-state logic. A CSR write takes priority over everything driven by
   // the external PPS: its strobe is discarded and both watchdogs hold for
   // that cycle. A wrap on the aligning cycle still counts as a second.
   always_comb begin
      state_next     = state;
      tick_next      = tick;
      seconds_next   = seconds;
      locked_next    = locked;
      lock_lost_next = lock_lost;
      arm_cnt_next   = arm_cnt;
      lock_cnt_next  = lock_cnt;
      marker_next    = (state != DISABLED) && (tick < TICK_PULSE);

      if (state != DISABLED) begin
         if (tick == TICK_LAST) begin
            tick_next    = '0;
            seconds_next = seconds + 28'd1;
         end else begin
            tick_next = tick + TICK_ONE;
         end
      end

      if (bus.csrStrobe) begin
         if (clear_req) begin
            lock_lost_next = 1'b0;
         end
         if (!enable_req) begin
            state_next  = DISABLED;
            tick_next   = '0;
            locked_next = 1'b0;
            marker_next = 1'b0;
         end else if (resync_req) begin
            state_next   = ARMED;
            locked_next  = 1'b0;
            arm_cnt_next = ARM_LAST;
            if (state == DISABLED) begin
               tick_next = '0;
            end
         end else if (state == DISABLED) begin
            state_next = RUN;
            tick_next  = '0;
         end
      end else begin
         case (state)
            ARMED: begin
               if (ext_strobe) begin
                  state_next    = RUN;
                  tick_next     = TICK_ALIGNED;
                  locked_next   = 1'b1;
                  lock_cnt_next = LOCK_LAST;
               end else if (arm_cnt == '0) begin
                  state_next = RUN;
               end else begin
                  arm_cnt_next = arm_cnt - ARM_ONE;
               end
            end
            RUN: begin
               if (locked) begin
                  if (ext_strobe) begin
                     if (phase_ok) begin
                        lock_cnt_next = LOCK_LAST;
                     end else begin
                        locked_next    = 1'b0;
                        lock_lost_next = 1'b1;
                     end
                  end else if (lock_cnt == '0) begin
                     locked_next    = 1'b0;
                     lock_lost_next = 1'b1;
                  end else begin
                     lock_cnt_next = lock_cnt - LOCK_ONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status snapshot, one cycle behind the internal state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.status <= '0;
      end else begin
         bus.status <= {state != DISABLED, state == ARMED, locked, lock_lost, seconds};
      end
   end

endmodule

// File: tb/tb_pps_marker_generator.sv
// tb_pps_marker_generator
// Purpose: self-checking bench for pps_marker_generator with a small
// behavioural model (phase counter, deadlines in absolute cycles, edge
// history) compared against the DUT every cycle, a directed vector table,
// hand-written corner sequences and a randomized phase.
module tb_pps_marker_generator;

   localparam int RATE         = 1000;
   localparam int PULSE        = 100;
   localparam int TOL          = 5;
   localparam int ALIGN        = 2;
   localparam int ARM_TIMEOUT  = 2 * RATE;
   localparam int LOCK_TIMEOUT = (RATE / 10) * 11;

   logic clk = 1'b0;
   logic rst_n;

   pps_marker_generator_if bus();

   pps_marker_generator #(
      .CLK_RATE   (RATE),
      .PULSE_TICKS(PULSE),
      .TOLERANCE  (TOL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state
   bit          m_enabled, m_armed, m_locked, m_lost, m_marker;
   int          m_tick;
   logic [27:0] m_sec;
   logic [31:0] m_status;
   int          arm_deadline, lock_deadline;
   bit          hist[4];

   typedef struct {
      bit          wr;
      logic [31:0] data;
      int          cycles;
      bit          exp_marker;
      logic [31:0] exp_status;
   } vec_t;

   vec_t vecs[13];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock edge of the reference model, using the inputs present at it.
   task automatic model_step();
      bit          strobe, marker_new;
      logic [31:0] status_new;
      int          next_tick, err;
      if (!rst_n) begin
         m_enabled = 0; m_armed = 0; m_locked = 0; m_lost = 0; m_marker = 0;
         m_tick = 0; m_sec = '0; m_status = '0;
         for (int k = 0; k < 4; k++) hist[k] = 0;
         return;
      end
      // rising edge seen three samples ago becomes visible now
      strobe  = hist[1] && !hist[0];
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = hist[3];
      hist[3] = bus.ppsExternal_a;

      status_new = {m_enabled, m_armed, m_locked, m_lost, m_sec};
      marker_new = m_enabled && (m_tick < PULSE);
      if (m_enabled && m_tick == RATE - 1) m_sec = m_sec + 28'd1;
      next_tick = m_enabled ? (m_tick + 1) % RATE : 0;

      if (bus.csrStrobe) begin
         if (bus.GPIO_OUT[29]) m_lost = 0;
         if (!bus.GPIO_OUT[31]) begin
            m_enabled = 0; m_armed = 0; m_locked = 0;
            next_tick = 0; marker_new = 0;
         end else if (bus.GPIO_OUT[30]) begin
            if (!m_enabled) next_tick = 0;
            m_enabled = 1; m_armed = 1; m_locked = 0;
            arm_deadline = cyc + ARM_TIMEOUT;
         end else if (!m_enabled) begin
            m_enabled = 1;
            next_tick = 0;
         end else if (m_armed) begin
            arm_deadline++;
         end else if (m_locked) begin
            lock_deadline++;
         end
      end else if (m_armed) begin
         if (strobe) begin
            next_tick = ALIGN + 1;
            m_armed = 0; m_locked = 1;
            lock_deadline = cyc + LOCK_TIMEOUT;
         end else if (cyc >= arm_deadline) begin
            m_armed = 0;
         end
      end else if (m_enabled && m_locked) begin
         if (strobe) begin
            err = (m_tick - ALIGN + RATE) % RATE;
            if (err <= TOL || err >= RATE - TOL) lock_deadline = cyc + LOCK_TIMEOUT;
            else begin m_locked = 0; m_lost = 1; end
         end else if (cyc >= lock_deadline) begin
            m_locked = 0; m_lost = 1;
         end
      end

      m_tick   = next_tick;
      m_marker = marker_new;
      m_status = status_new;
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         model_step();
         @(negedge clk);
         checkOutput("model_marker", 32'(bus.ppsMarker), 32'(m_marker));
         checkOutput("model_status", bus.status, m_status);
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic applyStimulus(input bit wr, input logic [31:0] data, input int cycles);
      bus.csrStrobe = wr;
      bus.GPIO_OUT  = data;
      step(1);
      bus.csrStrobe = 1'b0;
      bus.GPIO_OUT  = '0;
      if (cycles > 1) step(cycles - 1);
   endtask

   initial begin
      int          t0, t1, t2, w, s_last, next_pulse, pulse_end;
      logic [31:0] wd;

      vecs[0]  = '{1'b0, 32'h0000_0000,   1, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'h8000_0000,   1, 1'b0, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'h0000_0000,   1, 1'b1, 32'h8000_0000};
      vecs[3]  = '{1'b0, 32'h0000_0000,  99, 1'b1, 32'h8000_0000};
      vecs[4]  = '{1'b0, 32'h0000_0000,   1, 1'b0, 32'h8000_0000};
      vecs[5]  = '{1'b0, 32'h0000_0000, 899, 1'b0, 32'h8000_0000};
      vecs[6]  = '{1'b0, 32'h0000_0000,   1, 1'b1, 32'h8000_0001};
      vecs[7]  = '{1'b1, 32'h0000_0000,   1, 1'b0, 32'h8000_0001};
      vecs[8]  = '{1'b0, 32'h0000_0000,   1, 1'b0, 32'h0000_0001};
      vecs[9]  = '{1'b0, 32'h0000_0000, 500, 1'b0, 32'h0000_0001};
      vecs[10] = '{1'b1, 32'hC000_0000,   1, 1'b0, 32'h0000_0001};
      vecs[11] = '{1'b0, 32'h0000_0000,   1, 1'b1, 32'hC000_0001};
      vecs[12] = '{1'b0, 32'h0000_0000, 100, 1'b0, 32'hC000_0001};

      rst_n             = 1'b0;
      bus.csrStrobe     = 1'b0;
      bus.GPIO_OUT      = '0;
      bus.ppsExternal_a = 1'b0;
      step(3);
      rst_n = 1'b1;

      // directed vectors: enable, pulse width, seconds, disable mid-pulse, arm
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].cycles);
         checkOutput($sformatf("vec%0d_marker", i), 32'(bus.ppsMarker), 32'(vecs[i].exp_marker));
         checkOutput($sformatf("vec%0d_status", i), bus.status, vecs[i].exp_status);
      end

      // reset while armed
      rst_n = 1'b0;
      step(1);
      checkOutput("armed_reset_status", bus.status, 32'h0);
      checkOutput("armed_reset_marker", 32'(bus.ppsMarker), 32'h0);
      rst_n = 1'b1;

      // alignment to an external edge
      applyStimulus(1'b1, 32'hC000_0000, 50);
      t0 = cyc;
      bus.ppsExternal_a = 1'b1;
      step(5);
      checkOutput("align_status", 32'(bus.status[31:28]), 32'hA);
      bus.ppsExternal_a = 1'b0;
      run_to(t0 + 4 + 997);
      checkOutput("align_pre_rise", 32'(bus.ppsMarker), 32'h0);
      step(1);
      checkOutput("align_rise", 32'(bus.ppsMarker), 32'h1);

      // lock monitoring: on time, +3 (pass), +6 (fail), then clear lockLost
      run_to(t0 + 1000);
      bus.ppsExternal_a = 1'b1; step(5); bus.ppsExternal_a = 1'b0;
      run_to(t0 + 2003);
      bus.ppsExternal_a = 1'b1; step(5); bus.ppsExternal_a = 1'b0;
      checkOutput("shift3_lock", 32'(bus.status[29:28]), 32'h2);
      run_to(t0 + 3006);
      bus.ppsExternal_a = 1'b1; step(5); bus.ppsExternal_a = 1'b0;
      checkOutput("shift6_lost", 32'(bus.status[29:28]), 32'h1);
      applyStimulus(1'b1, 32'hA000_0000, 2);
      checkOutput("clear_lost", 32'(bus.status[31:28]), 32'h8);

      // armed with no external edge times out
      w = cyc + 1;
      applyStimulus(1'b1, 32'hC000_0000, 2);
      checkOutput("armed_set", 32'(bus.status[31:28]), 32'hC);
      run_to(w + 2000);
      checkOutput("armed_hold", 32'(bus.status[31:28]), 32'hC);
      step(1);
      checkOutput("armed_timeout", 32'(bus.status[31:28]), 32'h8);

      // external source stops while locked
      applyStimulus(1'b1, 32'hC000_0000, 20);
      t1 = cyc;
      bus.ppsExternal_a = 1'b1; step(5); bus.ppsExternal_a = 1'b0;
      checkOutput("relock", 32'(bus.status[31:28]), 32'hA);
      s_last = t1 + 4;
      run_to(s_last + 1100);
      checkOutput("wdog_hold", 32'(bus.status[29:28]), 32'h2);
      step(1);
      checkOutput("wdog_fire", 32'(bus.status[29:28]), 32'h1);

      // CSR write coinciding with extStrobe discards the strobe
      applyStimulus(1'b1, 32'hC000_0000, 10);
      t2 = cyc;
      bus.ppsExternal_a = 1'b1;
      step(3);
      applyStimulus(1'b1, 32'hA000_0000, 2);
      checkOutput("csr_wins", 32'(bus.status[31:28]), 32'hC);
      bus.ppsExternal_a = 1'b0;

      // randomized phase against the model
      applyStimulus(1'b1, 32'hC000_0000, 1);
      next_pulse = cyc + 200;
      pulse_end  = -1;
      for (int i = 0; i < 14000; i++) begin
         rst_n         = ($urandom_range(0, 6999) != 0);
         bus.csrStrobe = 1'b0;
         bus.GPIO_OUT  = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            wd     = $urandom;
            wd[31] = ($urandom_range(0, 7) != 0);
            bus.csrStrobe = 1'b1;
            bus.GPIO_OUT  = wd;
         end
         if (cyc == next_pulse) begin
            bus.ppsExternal_a = 1'b1;
            pulse_end = cyc + int'($urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0)
               next_pulse = cyc + RATE + int'($urandom_range(150, 400));
            else
               next_pulse = cyc + RATE - 8 + int'($urandom_range(0, 16));
         end else if (cyc == pulse_end) begin
            bus.ppsExternal_a = 1'b0;
         end
         step(1);
      end
      rst_n             = 1'b1;
      bus.csrStrobe     = 1'b0;
      bus.ppsExternal_a = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pps_marker_generator.md
Name: pps_marker_generator

Overview:
- Generates a 1 Hz acquisition marker (PPS) for frequency counters, event receivers and other consumers of an asynchronous PPS input.
- Runs free from the local clock. On CSR request it phase-aligns to an external PPS source and then monitors that source for lock.
- Uses the same csrStrobe / GPIO_OUT / status register-access pattern as other CSR blocks.

Parameters:
CLK_RATE, 100000000, clk frequency in Hz; marker period in clk cycles.
PULSE_TICKS, 10000000, marker high time in clk cycles (1 to CLK_RATE-1).
TOLERANCE, 100, allowed phase error of the external edge, in clk cycles, while locked.

Ports:
clk  input  1  system clock; everything is synchronous to it.
rst_n  input  1  synchronous, active-low reset.
csrStrobe  input  1  one-cycle CSR write strobe.
GPIO_OUT  input  32  CSR write data.
status  output  32  {enabled, armed, locked, lockLost, seconds[27:0]}.
ppsMarker  output  1  generated marker, registered.
ppsExternal_a  input  1  asynchronous external PPS.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=DISABLED; tick=0; seconds=0.
  - ppsMarker=0; locked=0; lockLost=0; status=0.
  - Reset mid-operation abandons any alignment in progress.
- CSR write (csrStrobe=1):
  - GPIO_OUT[31]=enable.
  - GPIO_OUT[30]=resync request, one-shot, ignored unless enable=1 in the same write.
  - GPIO_OUT[29]=1 clears lockLost.
  - Other bits ignored.
- External input:
  - 3-flop synchronizer (m, d0, d1); extStrobe <= d0 & !d1.
  - extStrobe asserts 4 clk after a rising edge on ppsExternal_a.
- Tick counter:
  - Counts 0..CLK_RATE-1 and wraps.
  - seconds increments (mod 2^28) on each wrap.
  - ppsMarker <= enabled && (tick < PULSE_TICKS), registered, so it is one cycle behind tick.
- States:
  - DISABLED: tick=0, seconds held, ppsMarker=0.
    - Write with enable=1 -> RUN with tick=0 next cycle; ppsMarker first rises the cycle after that.
    - If resync=1 in that same write -> ARMED instead.
  - RUN: free-running.
    - Write with enable=1, resync=1 -> ARMED; locked<=0.
  - ARMED: counter keeps running.
    - On extStrobe: tick<=ALIGN_TICK+1 (ALIGN_TICK=2); seconds unchanged; locked<=1; -> RUN.
    - Watchdog of 2*CLK_RATE cycles with no extStrobe -> RUN, locked stays 0.
  - Any state: write with enable=0 -> DISABLED next cycle; locked<=0; ppsMarker<=0.
- Lock monitoring (RUN with locked=1):
  - On each extStrobe, err = (tick - ALIGN_TICK) mod CLK_RATE.
  - Pass if err <= TOLERANCE or err >= CLK_RATE-TOLERANCE.
  - Fail: locked<=0, lockLost<=1. The counter is not re-aligned.
  - Edge watchdog: no extStrobe for (CLK_RATE/10)*11 cycles -> locked<=0, lockLost<=1. Watchdog reloads on every extStrobe.
- Simultaneous events:
  - A CSR write and extStrobe in the same cycle: the CSR write wins; the extStrobe is discarded.
  - Wrap and alignment in the same cycle: alignment wins; seconds still increments if tick was CLK_RATE-1.
- Status:
  - Registered, one cycle latency.
  - enabled=1 unless DISABLED; armed=1 in ARMED.
  - lockLost is sticky until cleared by GPIO_OUT[29] or reset.
- Width rules: tick is $clog2(CLK_RATE) bits; watchdogs are sized by $clog2 of their reload value plus 1.

Test Plan (CLK_RATE=1000, PULSE_TICKS=100, TOLERANCE=5):
1. Reset, then write 0x80000000 -> ppsMarker high for 100 cycles every 1000; status[27:0] increments each 1000 cycles; status[31]=1.
2. Write 0xC0000000, pulse ppsExternal_a at cycle T -> extStrobe at T+4; next ppsMarker rise at T+4+998; status[30:29]=2'b01 after alignment.
3. Locked, external pulses every 1000 cycles, then one pulse shifted +3 -> locked stays 1; shifted +6 -> locked=0, lockLost=1; write 0x20000000 with bit31=1 -> lockLost=0, generator keeps running.
4. Armed with no external pulse -> after 2000 cycles armed=0, locked=0, marker continues unshifted.
5. Locked, external source stopped -> lockLost=1 exactly 1100 cycles after the last extStrobe.
6. Write 0x00000000 mid-pulse -> ppsMarker=0 next cycle, status[31:29]=0, seconds held; rst_n=0 in ARMED -> status=0, ppsMarker=0.
